// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the mode sequencer and its per-key debouncers.
package mode_seq_pkg;

   localparam int NUM_KEYS = 2;
   localparam int CNT_W    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-flop synchronizer, stable-level debouncer and a rising-edge press pulse.
module key_debounce
   import mode_seq_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic press
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = key_raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      press_d = 1'b0;
      cnt_d   = cnt_q;
      // Any agreeing sample restarts the count, so short glitches never flip deb.
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         cnt_d   = '0;
         deb_d   = ~deb_q;
         press_d = ~deb_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Toggles mode bits on debounced key presses, then locks out further updates for
// HOLD_CYCLES while collecting presses that arrive meanwhile as pending toggles.
module mode_sequencer
   import mode_seq_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = 4,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] mode,
   output logic                mode_changed,
   output logic                busy
);

   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] merged;

   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] mode_q, mode_d;
   logic [NUM_KEYS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic                mode_changed_q, mode_changed_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key[gi]),
            .press   (press[gi])
         );
      end
   endgenerate

   assign merged = pending_q ^ press;

   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      pending_d      = pending_q;
      hold_d         = hold_q;
      mode_changed_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (press != '0) begin
               mode_d         = mode_q ^ press;
               mode_changed_d = 1'b1;
               hold_d         = HOLD_RELOAD;
               state_d        = HOLD;
            end
         end
         HOLD: begin
            if (hold_q == '0) begin
               // Expiry: apply any net toggle collected during the window, including this cycle's.
               pending_d = '0;
               if (merged != '0) begin
                  mode_d         = mode_q ^ merged;
                  mode_changed_d = 1'b1;
                  hold_d         = HOLD_RELOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               pending_d = merged;
               hold_d    = hold_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         mode_q         <= '0;
         pending_q      <= '0;
         hold_q         <= '0;
         mode_changed_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         pending_q      <= pending_d;
         hold_q         <= hold_d;
         mode_changed_q <= mode_changed_d;
      end
   end

   assign mode         = mode_q;
   assign mode_changed = mode_changed_q;
   assign busy         = (state_q == HOLD);

endmodule

// File: tb/tb_mode_sequencer.sv
// Randomized and directed stimulus for mode_sequencer, checked every cycle against a
// timestamp-based reference model of key filtering and lockout windows.
module tb_mode_sequencer;

   localparam int DB    = 4;
   localparam int HOLD  = 8;
   localparam int MAXC  = 8000;

   logic       clk;
   logic       rst_n;
   logic [1:0] key;
   logic [1:0] mode;
   logic       mode_changed;
   logic       busy;

   int checks_cnt;
   int errors_cnt;

   // Reference model state
   logic [1:0] hist [0:MAXC-1];
   int         t;
   logic [1:0] m_mode;
   logic       m_mc;
   logic       m_busy;
   logic [1:0] m_pend;
   logic [1:0] m_deb;
   logic [1:0] m_press;
   int         m_wend;

   int first_mc;
   int mc_cnt;
   int busy_cnt;
   int e_edge;

   mode_sequencer #(
      .DB_CYCLES   (DB),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key          (key),
      .mode         (mode),
      .mode_changed (mode_changed),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      checks_cnt++;
      if (obs != exp_v) begin
         errors_cnt++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, t, obs, exp_v);
      end
   endtask

   // Advance the model by one rising edge using the inputs applied for that edge.
   task automatic model_edge();
      logic [1:0] q;
      logic [1:0] rise;
      logic       all_diff;
      hist[t] = key;
      if (!rst_n) begin
         m_mode  = 2'b00;
         m_mc    = 1'b0;
         m_busy  = 1'b0;
         m_pend  = 2'b00;
         m_deb   = 2'b00;
         m_press = 2'b00;
         // Synchronizers are cleared, so the debouncer sees zeros for the next two edges.
         hist[t] = 2'b00;
         if (t > 0) hist[t-1] = 2'b00;
      end else begin
         m_mc = 1'b0;
         if (!m_busy) begin
            if (m_press != 2'b00) begin
               m_mode = m_mode ^ m_press;
               m_mc   = 1'b1;
               m_busy = 1'b1;
               m_wend = t + HOLD;
            end
         end else if (t == m_wend) begin
            q      = m_pend ^ m_press;
            m_pend = 2'b00;
            if (q != 2'b00) begin
               m_mode = m_mode ^ q;
               m_mc   = 1'b1;
               m_wend = t + HOLD;
            end else begin
               m_busy = 1'b0;
            end
         end else begin
            m_pend = m_pend ^ m_press;
         end
         // Debounced level flips once the last DB synchronized samples all disagree with it.
         rise = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (t >= DB + 1) begin
               all_diff = 1'b1;
               for (int k = 0; k < DB; k++)
                  if (hist[t-2-k][i] == m_deb[i]) all_diff = 1'b0;
               if (all_diff) begin
                  m_deb[i] = ~m_deb[i];
                  if (m_deb[i]) rise[i] = 1'b1;
               end
            end
         end
         m_press = rise;
      end
      t++;
   endtask

   task automatic step(input logic [1:0] kv, input logic rv);
      @(negedge clk);
      key   = kv;
      rst_n = rv;
      @(posedge clk);
      model_edge();
      #1;
      check("mode", int'(mode), int'(m_mode));
      check("mode_changed", int'(mode_changed), int'(m_mc));
      check("busy", int'(busy), int'(m_busy));
      if (mode_changed) begin
         mc_cnt++;
         if (first_mc < 0) first_mc = t - 1;
      end
      if (busy) busy_cnt++;
   endtask

   task automatic clear_stats();
      first_mc = -1;
      mc_cnt   = 0;
      busy_cnt = 0;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      t          = 0;
      m_wend     = 0;
      key        = 2'b00;
      rst_n      = 1'b0;
      m_mode = 2'b00; m_mc = 1'b0; m_busy = 1'b0;
      m_pend = 2'b00; m_deb = 2'b00; m_press = 2'b00;
      clear_stats();

      repeat (3) step(2'b00, 1'b0);
      check("reset_mode", int'(mode), 0);
      check("reset_busy", int'(busy), 0);

      // Single key0 press: latency, one pulse, eight busy cycles.
      clear_stats();
      e_edge = t;
      repeat (30) step(2'b01, 1'b1);
      check("press_latency", first_mc, e_edge + DB + 2);
      check("press_pulses", mc_cnt, 1);
      check("press_busy_cycles", busy_cnt, HOLD);
      check("press_mode", int'(mode), 1);
      repeat (20) step(2'b00, 1'b1);

      // Three-cycle glitch on key1 is filtered.
      clear_stats();
      repeat (3) step(2'b10, 1'b1);
      repeat (20) step(2'b00, 1'b1);
      check("glitch_pulses", mc_cnt, 0);
      check("glitch_mode", int'(mode), 1);

      // Both keys together from mode 00 give one combined update.
      step(2'b00, 1'b0);
      clear_stats();
      repeat (30) step(2'b11, 1'b1);
      check("both_pulses", mc_cnt, 1);
      check("both_mode", int'(mode), 3);
      repeat (20) step(2'b00, 1'b1);

      // Second key0 press lands exactly at HOLD expiry and extends the lockout.
      step(2'b00, 1'b0);
      clear_stats();
      e_edge = t;
      repeat (4) step(2'b01, 1'b1);
      repeat (4) step(2'b00, 1'b1);
      repeat (20) step(2'b01, 1'b1);
      check("hold_pulses", mc_cnt, 2);
      check("hold_busy_cycles", busy_cnt, 2 * HOLD);
      check("hold_mode", int'(mode), 0);
      repeat (20) step(2'b00, 1'b1);

      // Reset during HOLD with a pending key1 toggle discards it.
      step(2'b00, 1'b0);
      repeat (4) step(2'b01, 1'b1);
      repeat (4) step(2'b10, 1'b1);
      repeat (3) step(2'b00, 1'b1);
      step(2'b00, 1'b0);
      check("rst_mid_mode", int'(mode), 0);
      check("rst_mid_busy", int'(busy), 0);
      clear_stats();
      repeat (30) step(2'b00, 1'b1);
      check("rst_mid_pulses", mc_cnt, 0);

      // Random key segments with occasional resets.
      while (t < 4000) begin
         logic [1:0] kv;
         int         len;
         kv  = 2'($urandom_range(0, 3));
         len = int'($urandom_range(1, 12));
         for (int n = 0; n < len; n++)
            step(kv, ($urandom_range(0, 299) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable sync samples required to accept a key level change (range 2..255).
REQ-002 Parameter HOLD_CYCLES, default 8: lockout cycles after each mode update (range 1..255).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key  input  2  raw asynchronous push keys, active-high, bit i toggles mode[i].
REQ-006 mode  output  2  registered mode word.
REQ-007 mode_changed  output  1  registered one-cycle pulse coincident with each mode update.
REQ-008 busy  output  1  high while in HOLD.

Function
REQ-009 Each key bit shall pass through a 2-flop synchronizer before any other use.
REQ-010 Per key, debounced level deb shall change only after DB_CYCLES consecutive cycles in which the synchronized value differs from deb.
REQ-011 The mismatch counter shall clear on any cycle where the synchronized value equals deb; glitches shorter than DB_CYCLES cycles shall never change deb.
REQ-012 Per key, press[i] shall be a registered one-cycle pulse, high in the cycle after deb[i] rises; deb falling produces no pulse.
REQ-013 FSM states: IDLE, HOLD.
REQ-014 IDLE with press != 0: mode <= mode XOR press; mode_changed = 1 for that cycle; hold counter <= HOLD_CYCLES-1; go to HOLD.
REQ-015 IDLE with press == 0: no change; mode_changed = 0.
REQ-016 HOLD: pending <= pending XOR press each cycle; counter decrements each cycle.
REQ-017 HOLD with counter == 0: let p = pending XOR press; if p != 0, then mode <= mode XOR p, pulse mode_changed, clear pending, reload counter, and stay in HOLD; else go to IDLE.
REQ-018 Simultaneous presses on both keys in one cycle shall toggle both mode bits in one update (mode XOR 2'b11).
REQ-019 Two presses of the same key within one HOLD window shall cancel, leaving no net update.
REQ-020 Latency: raw key first sampled high at edge E, stable thereafter, FSM in IDLE: mode updates at edge E+DB_CYCLES+2.
REQ-021 busy = (state == HOLD); mode_changed never high on two consecutive cycles unless HOLD_CYCLES == 1.

Reset
REQ-022 While rst_n is low at a clock edge: mode=2'b00, mode_changed=0, busy=0, state=IDLE, pending=0, hold counter=0, synchronizers=0, deb=0, press=0, debounce counters=0.
REQ-023 Reset asserted mid-HOLD shall discard pending toggles; no update occurs after reset release.
REQ-024 A key held high across reset release shall be treated as a new press after DB_CYCLES+2 cycles.

Structure
REQ-025 Shared package mode_seq_pkg holds the state enum (IDLE, HOLD), NUM_KEYS=2, and counter width constant CNT_W=8.
REQ-026 Sub-module key_debounce (synchronizer, debounce counter, press pulse) shall be instantiated once per key; the FSM, pending register, and hold counter live in mode_sequencer.

Verification
REQ-027 Reset then hold key=2'b01 high with defaults -> mode=01 at edge E+6, mode_changed high exactly 1 cycle, busy high 8 cycles.
REQ-028 Key[1] high for 3 cycles then low (DB_CYCLES=4) -> no press, mode stays 00, mode_changed never asserts.
REQ-029 Both keys rise in the same cycle from mode=00 -> a single update to mode=11 with one mode_changed pulse.
REQ-030 Key[0] press lands during HOLD -> no change until HOLD ends, then mode[0] toggles at HOLD expiry with mode_changed, busy stays high another 8 cycles.
REQ-031 Key[1] pressed twice within one HOLD window -> pending cancels, FSM returns to IDLE, mode unchanged.
REQ-032 rst_n low for 1 cycle mid-HOLD with pending=01 -> mode=00, busy=0 next cycle, no later update.
